// File: rtl/cm3_ahb_pkg.sv
// Shared AHB-Lite definitions for the register responder.
// Contents: HTRANS / HRESP / HSIZE codes, responder FSM state enum and the
// byte-strobe helper used by the optional sub-word write path.
package cm3_ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } rsp_state_e;

  // Byte lanes touched by an aligned access of the given size/offset.
  function automatic logic [3:0] lane_strb(input logic [2:0] size, input logic [1:0] off);
    logic [3:0] s;
    case (size)
      HSIZE_BYTE: s = 4'b0001 << off;
      HSIZE_HALF: s = off[1] ? 4'b1100 : 4'b0011;
      default:    s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/cm3_reg_file.sv
// NUM_REGS x 32-bit register storage with a read-only ID slot.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset (all regs -> RESET_VAL)
//   we, strb, widx,   write enable, byte strobe, word index, write data
//   wdata
//   ridx, rdata       read index and combinational read data (ID at NUM_REGS,
//                     zero beyond)
//   regs_out          flat image, reg i at [32*i+31:32*i]
module cm3_reg_file #(
  parameter int          NUM_REGS  = 8,
  parameter logic [31:0] ID_VALUE  = 32'hC3A0_0001,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     we,
  input  logic [3:0]               strb,
  input  logic [5:0]               widx,
  input  logic [31:0]              wdata,
  input  logic [5:0]               ridx,
  output logic [31:0]              rdata,
  output logic [NUM_REGS*32-1:0]   regs_out
);

  logic [NUM_REGS-1:0][31:0] regs;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        regs[i] <= RESET_VAL;
      end else if (we && (int'(widx) == i)) begin
        for (int b = 0; b < 4; b++)
          if (strb[b]) regs[i][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (int'(ridx) == NUM_REGS) rdata = ID_VALUE;
    for (int i = 0; i < NUM_REGS; i++)
      if (int'(ridx) == i) rdata = regs[i];
  end

  assign regs_out = regs;

endmodule

// File: rtl/cm3_ahb_reg_responder.sv
// AHB-Lite register responder terminating one bus-matrix output port.
// NUM_REGS R/W registers at word indices 0..NUM_REGS-1, read-only ID at
// index NUM_REGS, WAIT_STATES wait cycles before OKAY, two-cycle ERROR.
// Ports: HCLK/HRESETn (sync active-low), AHB slave inputs HSEL, HADDR,
//   HTRANS, HWRITE, HSIZE, HREADY, HWDATA; outputs HREADYOUT, HRESP,
//   HRDATA, HRUSER (tied 0); regs_out = flat register image.
// Optional macro CM3_REG_RESP_SUBWORD_EN: enables byte/halfword writes;
//   when undefined any non-word HSIZE returns ERROR.
module cm3_ahb_reg_responder
  import cm3_ahb_pkg::*;
#(
  parameter int          NUM_REGS    = 8,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hC3A0_0001,
  parameter logic [31:0] RESET_VAL   = 32'h0000_0000
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   HSEL,
  input  logic [31:0]            HADDR,
  input  logic [1:0]             HTRANS,
  input  logic                   HWRITE,
  input  logic [2:0]             HSIZE,
  input  logic                   HREADY,
  input  logic [31:0]            HWDATA,
  output logic                   HREADYOUT,
  output logic [1:0]             HRESP,
  output logic [31:0]            HRDATA,
  output logic [31:0]            HRUSER,
  output logic [NUM_REGS*32-1:0] regs_out
);

  rsp_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [5:0]  idx_q, idx_d;
  logic        wr_q, wr_d;
  logic [2:0]  size_q, size_d;
  logic [1:0]  off_q, off_d;

  logic        accept, acc_err, we;
  logic [5:0]  acc_idx;
  logic [3:0]  strb;
  logic [31:0] rdata;

  assign accept  = HSEL & HREADY & HTRANS[1];
  assign acc_idx = HADDR[7:2];

  // Error decode on the address phase; the error flag is carried forward
  // as the ERR1/ERR2 state rather than a separate register.
  always_comb begin
    acc_err = 1'b0;
    if (HSIZE > HSIZE_WORD) acc_err = 1'b1;
    if ((HSIZE == HSIZE_HALF) && HADDR[0]) acc_err = 1'b1;
    if ((HSIZE == HSIZE_WORD) && (HADDR[1:0] != 2'b00)) acc_err = 1'b1;
    if ({1'b0, acc_idx} > 7'(NUM_REGS)) acc_err = 1'b1;
    if (HWRITE && ({1'b0, acc_idx} == 7'(NUM_REGS))) acc_err = 1'b1;
`ifndef CM3_REG_RESP_SUBWORD_EN
    if (HSIZE != HSIZE_WORD) acc_err = 1'b1;
`endif
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      size_q  <= HSIZE_WORD;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      off_q   <= off_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wr_d      = wr_q;
    size_d    = size_q;
    off_d     = off_q;
    HREADYOUT = 1'b1;
    HRESP     = HRESP_OKAY;
    we        = 1'b0;
    // The write of the completing DATA cycle uses idx_q (old capture);
    // a same-cycle accept only changes the *_d values.
    case (state_q)
      ST_WAIT: begin
        HREADYOUT = 1'b0;
        if (cnt_q <= 4'd1) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_DATA: begin
        we      = wr_q;
        state_d = ST_IDLE;
      end
      ST_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = HRESP_ERROR;
        state_d   = ST_ERR2;
      end
      ST_ERR2: begin
        HRESP   = HRESP_ERROR;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // New address phases are only taken in cycles that complete (or idle).
    if (accept && HREADYOUT) begin
      if (acc_err)               state_d = ST_ERR1;
      else if (WAIT_STATES == 0) state_d = ST_DATA;
      else                       state_d = ST_WAIT;
      cnt_d  = 4'(WAIT_STATES);
      idx_d  = acc_idx;
      wr_d   = HWRITE;
      size_d = HSIZE;
      off_d  = HADDR[1:0];
    end
  end

`ifdef CM3_REG_RESP_SUBWORD_EN
  assign strb = lane_strb(size_q, off_q);
  logic unused_in;
  assign unused_in = ^{HADDR[31:8], HTRANS[0]};
`else
  assign strb = 4'hF;
  logic unused_in;
  assign unused_in = ^{HADDR[31:8], HTRANS[0], size_q, off_q};
`endif

  cm3_reg_file #(
    .NUM_REGS  (NUM_REGS),
    .ID_VALUE  (ID_VALUE),
    .RESET_VAL (RESET_VAL)
  ) u_rf (
    .clk      (HCLK),
    .rst_n    (HRESETn),
    .we       (we),
    .strb     (strb),
    .widx     (idx_q),
    .wdata    (HWDATA),
    .ridx     (idx_q),
    .rdata    (rdata),
    .regs_out (regs_out)
  );

  // Reads are combinational from the register file, so a read right after
  // a write to the same index sees the value committed at the prior edge.
  assign HRDATA = (!wr_q && (state_q == ST_WAIT || state_q == ST_DATA)) ? rdata : 32'h0;
  assign HRUSER = 32'h0;

endmodule

// File: tb/tb_cm3_ahb_reg_responder.sv
module tb_cm3_ahb_reg_responder;

  localparam int NR = 8;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic          HWRITE;
  logic [2:0]    HSIZE;
  logic          HREADY;
  logic [31:0]   HWDATA;
  logic          HREADYOUT;
  logic [1:0]    HRESP;
  logic [31:0]   HRDATA;
  logic [31:0]   HRUSER;
  logic [NR*32-1:0] regs_out;
  logic          hrdy_en;

  int n_chk = 0;
  int n_err = 0;

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT & hrdy_en;

  cm3_ahb_reg_responder #(
    .NUM_REGS(NR), .WAIT_STATES(1), .ID_VALUE(32'hC3A0_0001), .RESET_VAL(32'h0)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HSIZE(HSIZE), .HREADY(HREADY), .HWDATA(HWDATA),
    .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .HRUSER(HRUSER),
    .regs_out(regs_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'b010; HADDR = '0;
  endtask

  // One isolated transfer; expects WAIT_STATES=1 so both OKAY and ERROR
  // take exactly two data-phase cycles with HREADYOUT low then high.
  task automatic xfer(input string tag, input logic [31:0] a, input logic w,
                      input logic [2:0] sz, input logic [31:0] wd,
                      input logic err, input logic [31:0] exp_rd);
    int n;
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = w; HSIZE = sz;
    @(posedge HCLK); #1;
    bus_idle(); HWDATA = wd;
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
      if (n == 1) begin
        chk({tag, "_rdy1"}, {31'b0, HREADYOUT}, 32'd0);
        chk({tag, "_resp1"}, {30'b0, HRESP}, err ? 32'd1 : 32'd0);
      end
    end while (!HREADYOUT && n < 20);
    chk({tag, "_cyc"}, n, 32'd2);
    chk({tag, "_resp2"}, {30'b0, HRESP}, err ? 32'd1 : 32'd0);
    chk({tag, "_rdata"}, HRDATA, (w || err) ? 32'd0 : exp_rd);
  endtask

  initial begin
    HRESETn = 1'b0; hrdy_en = 1'b1; HWDATA = '0;
    bus_idle();
    repeat (3) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(negedge HCLK);
    chk("rst_rdy", {31'b0, HREADYOUT}, 32'd1);
    chk("rst_resp", {30'b0, HRESP}, 32'd0);
    chk("rst_rdata", HRDATA, 32'd0);
    chk("rst_regs", {31'b0, |regs_out}, 32'd0);
    chk("hruser", HRUSER, 32'd0);

    // Word write idx2 then read back
    xfer("wr2", 32'h08, 1'b1, 3'b010, 32'hDEAD_BEEF, 1'b0, 32'h0);
    @(posedge HCLK); #1;
    chk("wr2_reg", regs_out[95:64], 32'hDEAD_BEEF);
    xfer("rd2", 32'h08, 1'b0, 3'b010, 32'h0, 1'b0, 32'hDEAD_BEEF);

    // ID register: readable, write is an error and leaves it alone
    xfer("rd_id", 32'h20, 1'b0, 3'b010, 32'h0, 1'b0, 32'hC3A0_0001);
    xfer("wr_id", 32'h20, 1'b1, 3'b010, 32'h1234_5678, 1'b1, 32'h0);
    xfer("rd_id2", 32'h20, 1'b0, 3'b010, 32'h0, 1'b0, 32'hC3A0_0001);

    // Out of range index and misaligned word
    xfer("rd_oor", 32'h24, 1'b0, 3'b010, 32'h0, 1'b1, 32'h0);
    xfer("misal", 32'h02, 1'b0, 3'b010, 32'h0, 1'b1, 32'h0);
    xfer("bad_sz", 32'h00, 1'b0, 3'b011, 32'h0, 1'b1, 32'h0);

    // Back-to-back write idx1 then read idx1 accepted in the write's DATA cycle
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h04; HWRITE = 1'b1; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    HWDATA = 32'h1111_1111; HWRITE = 1'b0;
    @(negedge HCLK);
    chk("b2b_w_rdy1", {31'b0, HREADYOUT}, 32'd0);
    @(negedge HCLK);
    chk("b2b_w_rdy2", {31'b0, HREADYOUT}, 32'd1);
    @(posedge HCLK); #1;
    bus_idle();
    @(negedge HCLK);
    chk("b2b_r_rdy1", {31'b0, HREADYOUT}, 32'd0);
    chk("b2b_reg1", regs_out[63:32], 32'h1111_1111);
    @(negedge HCLK);
    chk("b2b_r_rdy2", {31'b0, HREADYOUT}, 32'd1);
    chk("b2b_r_data", HRDATA, 32'h1111_1111);

    // Byte write 0xAB to byte lane 1 of idx1
`ifdef CM3_REG_RESP_SUBWORD_EN
    xfer("bwr", 32'h05, 1'b1, 3'b000, 32'h0000_AB00, 1'b0, 32'h0);
    @(posedge HCLK); #1;
    chk("bwr_reg", regs_out[63:32], 32'h1111_AB11);
`else
    xfer("bwr", 32'h05, 1'b1, 3'b000, 32'h0000_AB00, 1'b1, 32'h0);
    @(posedge HCLK); #1;
    chk("bwr_reg", regs_out[63:32], 32'h1111_1111);
`endif

    // Address phase with HREADY low is ignored
    @(posedge HCLK); #1;
    hrdy_en = 1'b0;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h20; HWRITE = 1'b0;
    @(posedge HCLK); #1;
    bus_idle(); hrdy_en = 1'b1;
    @(negedge HCLK);
    chk("nrdy_rdy", {31'b0, HREADYOUT}, 32'd1);
    chk("nrdy_rdata", HRDATA, 32'd0);

    // Reset during WAIT of a write to idx3
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0C; HWRITE = 1'b1; HSIZE = 3'b010;
    @(posedge HCLK); #1;
    bus_idle(); HWDATA = 32'h3333_3333; HRESETn = 1'b0;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(negedge HCLK);
    chk("rst_mid_rdy", {31'b0, HREADYOUT}, 32'd1);
    chk("rst_mid_resp", {30'b0, HRESP}, 32'd0);
    chk("rst_mid_reg3", regs_out[127:96], 32'h0);
    chk("rst_mid_reg2", regs_out[95:64], 32'h0);
    repeat (2) @(negedge HCLK);
    chk("rst_mid_reg3b", regs_out[127:96], 32'h0);

    // HSEL with IDLE transfer: zero-wait OKAY
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b00; HADDR = 32'h24;
    @(posedge HCLK); #1;
    bus_idle();
    @(negedge HCLK);
    chk("idle_rdy", {31'b0, HREADYOUT}, 32'd1);
    chk("idle_resp", {30'b0, HRESP}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
